// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the external memory loader.
// Holds the loader FSM states, the write-slot and write-phase encodings, and
// the default command bytes used by mem_loader.
package mem_loader_pkg;

  localparam logic [7:0] DEF_CMD_RAM   = 8'h57;
  localparam logic [7:0] DEF_CMD_INSTR = 8'h49;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_HALT_WAIT,
    ST_DATA_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SLOT_MAR1,
    SLOT_MAR0,
    SLOT_MEM
  } slot_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/mem_loader_write.sv
// mem_write_slot: three-phase (SETUP / STROBE / HOLD) write-strobe sequencer.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start              begin a slot (latched next edge, SETUP phase)
//   i_slot               which strobe this slot drives (MAR1, MAR0, MEM)
//   i_memIsInstr         MEM slot uses the instruction strobe instead of RAM
//   i_value              bus value held for the whole slot
//   o_bus                registered bus value
//   o_mar1NWE/o_mar0NWE/o_ramNWE/o_instrNWE  active-low strobes (registered)
//   o_slotDone           high during the HOLD phase; a new start may be
//                        issued in that cycle for back-to-back slots
module mem_write_slot
  import mem_loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  slot_t      i_slot,
  input  logic       i_memIsInstr,
  input  logic [7:0] i_value,
  output logic [7:0] o_bus,
  output logic       o_mar1NWE,
  output logic       o_mar0NWE,
  output logic       o_ramNWE,
  output logic       o_instrNWE,
  output logic       o_slotDone
);

  logic   r_active;
  phase_t r_phase;
  slot_t  r_slot;
  logic   r_memIsInstr;

  assign o_slotDone = r_active && (r_phase == PH_HOLD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active     <= 1'b0;
      r_phase      <= PH_SETUP;
      r_slot       <= SLOT_MAR0;
      r_memIsInstr <= 1'b0;
      o_bus        <= '0;
      o_mar1NWE    <= 1'b1;
      o_mar0NWE    <= 1'b1;
      o_ramNWE     <= 1'b1;
      o_instrNWE   <= 1'b1;
    end else begin
      o_mar1NWE  <= 1'b1;
      o_mar0NWE  <= 1'b1;
      o_ramNWE   <= 1'b1;
      o_instrNWE <= 1'b1;
      if (i_start) begin
        r_active     <= 1'b1;
        r_phase      <= PH_SETUP;
        r_slot       <= i_slot;
        r_memIsInstr <= i_memIsInstr;
        o_bus        <= i_value;
      end else if (r_active) begin
        unique case (r_phase)
          PH_SETUP: begin
            // Strobe is registered, so it is pulled low on the edge that
            // enters STROBE and released on the edge that enters HOLD.
            r_phase <= PH_STROBE;
            unique case (r_slot)
              SLOT_MAR1: o_mar1NWE <= 1'b0;
              SLOT_MAR0: o_mar0NWE <= 1'b0;
              default: begin
                if (r_memIsInstr) o_instrNWE <= 1'b0;
                else              o_ramNWE   <= 1'b0;
              end
            endcase
          end
          PH_STROBE: r_phase <= PH_HOLD;
          default:   r_active <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream program/data loader for the 8-bit datapath.
// Parses CMD, ADDR_HI, ADDR_LO, LEN, data*LEN from a valid/ready stream,
// requests a CPU halt, then writes MAR1/MAR0/RAM-or-INSTR through the memory
// strobes while o_busOE is high.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rxData/i_rxValid/o_rxReady  input byte stream handshake
//   o_haltReq, i_haltAck      CPU halt handshake
//   o_busOE, o_bus            bus ownership and value
//   o_ctrlMem*NWE             active-low MAR1/MAR0/RAM/INSTR write strobes
//   o_done                    one-cycle pulse at packet end
//   o_error                   sticky unknown-command flag
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [7:0] CMD_RAM   = DEF_CMD_RAM,
  parameter logic [7:0] CMD_INSTR = DEF_CMD_INSTR
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rxData,
  input  logic       i_rxValid,
  output logic       o_rxReady,
  output logic       o_haltReq,
  input  logic       i_haltAck,
  output logic       o_busOE,
  output logic [7:0] o_bus,
  output logic       o_ctrlMemMar0NWE,
  output logic       o_ctrlMemMar1NWE,
  output logic       o_ctrlMemRamNWE,
  output logic       o_ctrlMemInstrNWE,
  output logic       o_done,
  output logic       o_error
);

  state_t      r_state, w_stateNext;
  logic [15:0] r_addr, w_addrNext;
  logic [8:0]  r_rem, w_remNext;
  logic [7:0]  r_data, w_dataNext;
  logic        r_cmdInstr, w_cmdInstrNext;
  logic        r_mar1Dirty, w_dirtyNext;
  logic        r_error, w_errorNext;
  logic        r_kick, w_kickNext;
  slot_t       r_slot, w_slotNext;
  logic        w_slotStart;
  logic [7:0]  w_slotValue;
  logic        w_slotDone;
  logic        w_accept;

  assign w_accept = i_rxValid && o_rxReady;
  assign o_error  = r_error;

  always_comb begin
    w_stateNext    = r_state;
    w_addrNext     = r_addr;
    w_remNext      = r_rem;
    w_dataNext     = r_data;
    w_cmdInstrNext = r_cmdInstr;
    w_dirtyNext    = r_mar1Dirty;
    w_errorNext    = r_error;
    w_kickNext     = 1'b0;
    w_slotNext     = r_slot;
    w_slotStart    = 1'b0;
    w_slotValue    = '0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        if (i_rxData == CMD_RAM) begin
          w_cmdInstrNext = 1'b0;
          w_stateNext    = ST_ADDR_HI;
        end else if (i_rxData == CMD_INSTR) begin
          w_cmdInstrNext = 1'b1;
          w_stateNext    = ST_ADDR_HI;
        end else begin
          w_errorNext = 1'b1;
        end
      end
      ST_ADDR_HI: if (w_accept) begin
        w_addrNext[15:8] = i_rxData;
        w_stateNext      = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (w_accept) begin
        w_addrNext[7:0] = i_rxData;
        w_stateNext     = ST_LEN;
      end
      ST_LEN: if (w_accept) begin
        w_remNext   = (i_rxData == 8'h00) ? 9'd256 : {1'b0, i_rxData};
        w_dirtyNext = 1'b1;
        w_stateNext = ST_HALT_WAIT;
      end
      ST_HALT_WAIT: if (i_haltAck) w_stateNext = ST_DATA_WAIT;
      ST_DATA_WAIT: if (w_accept) begin
        w_dataNext  = i_rxData;
        w_kickNext  = 1'b1;
        w_stateNext = ST_WRITE;
      end
      ST_WRITE: begin
        // First slot is launched from the first WRITE cycle (r_kick); later
        // slots are launched during the previous slot's HOLD so they run
        // back to back.
        if (r_kick) begin
          w_slotStart = 1'b1;
          w_slotNext  = r_mar1Dirty ? SLOT_MAR1 : SLOT_MAR0;
          w_slotValue = r_mar1Dirty ? r_addr[15:8] : r_addr[7:0];
        end else if (w_slotDone) begin
          unique case (r_slot)
            SLOT_MAR1: begin
              w_dirtyNext = 1'b0;
              w_slotStart = 1'b1;
              w_slotNext  = SLOT_MAR0;
              w_slotValue = r_addr[7:0];
            end
            SLOT_MAR0: begin
              w_slotStart = 1'b1;
              w_slotNext  = SLOT_MEM;
              w_slotValue = r_data;
            end
            default: begin
              w_addrNext = r_addr + 16'd1;
              if (r_addr[7:0] == 8'hFF) w_dirtyNext = 1'b1;
              w_remNext   = r_rem - 9'd1;
              w_stateNext = (r_rem == 9'd1) ? ST_DONE : ST_DATA_WAIT;
            end
          endcase
        end
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_data      <= '0;
      r_cmdInstr  <= 1'b0;
      r_mar1Dirty <= 1'b0;
      r_error     <= 1'b0;
      r_kick      <= 1'b0;
      r_slot      <= SLOT_MAR0;
      o_rxReady   <= 1'b1;
      o_haltReq   <= 1'b0;
      o_busOE     <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_addr      <= w_addrNext;
      r_rem       <= w_remNext;
      r_data      <= w_dataNext;
      r_cmdInstr  <= w_cmdInstrNext;
      r_mar1Dirty <= w_dirtyNext;
      r_error     <= w_errorNext;
      r_kick      <= w_kickNext;
      r_slot      <= w_slotNext;
      // Outputs are registered decodes of the next state.
      o_rxReady   <= (w_stateNext == ST_IDLE)   || (w_stateNext == ST_ADDR_HI) ||
                     (w_stateNext == ST_ADDR_LO) || (w_stateNext == ST_LEN) ||
                     (w_stateNext == ST_DATA_WAIT);
      o_haltReq   <= (w_stateNext == ST_HALT_WAIT) || (w_stateNext == ST_DATA_WAIT) ||
                     (w_stateNext == ST_WRITE);
      o_busOE     <= (w_stateNext == ST_DATA_WAIT) || (w_stateNext == ST_WRITE);
      o_done      <= (w_stateNext == ST_DONE);
    end
  end

  mem_write_slot u_slot (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_slotStart),
    .i_slot       (w_slotNext),
    .i_memIsInstr (r_cmdInstr),
    .i_value      (w_slotValue),
    .o_bus        (o_bus),
    .o_mar1NWE    (o_ctrlMemMar1NWE),
    .o_mar0NWE    (o_ctrlMemMar0NWE),
    .o_ramNWE     (o_ctrlMemRamNWE),
    .o_instrNWE   (o_ctrlMemInstrNWE),
    .o_slotDone   (w_slotDone)
  );

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed packets with hand-computed
// strobe/bus sequences, timing, halt handshake, error flag and reset.
module tb_mem_loader;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rxData = '0;
  logic       i_rxValid = 1'b0;
  logic       i_haltAck = 1'b1;
  logic       o_rxReady, o_haltReq, o_busOE, o_done, o_error;
  logic [7:0] o_bus;
  logic       o_ctrlMemMar0NWE, o_ctrlMemMar1NWE, o_ctrlMemRamNWE, o_ctrlMemInstrNWE;

  mem_loader #(.CMD_RAM(8'h57), .CMD_INSTR(8'h49)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_rxData          (i_rxData),
    .i_rxValid         (i_rxValid),
    .o_rxReady         (o_rxReady),
    .o_haltReq         (o_haltReq),
    .i_haltAck         (i_haltAck),
    .o_busOE           (o_busOE),
    .o_bus             (o_bus),
    .o_ctrlMemMar0NWE  (o_ctrlMemMar0NWE),
    .o_ctrlMemMar1NWE  (o_ctrlMemMar1NWE),
    .o_ctrlMemRamNWE   (o_ctrlMemRamNWE),
    .o_ctrlMemInstrNWE (o_ctrlMemInstrNWE),
    .o_done            (o_done),
    .o_error           (o_error)
  );

  always #5 i_clk = ~i_clk;

  localparam int K_MAR1 = 0, K_MAR0 = 1, K_RAM = 2, K_INSTR = 3;

  typedef struct {
    int         k;
    logic [7:0] v;
    int         c;
  } ev_t;

  ev_t        ev[$];
  logic [9:0] exp_q[$];
  int         cyc = 0;
  int         viol = 0;
  int         n_checks = 0;
  int         n_err = 0;
  int         acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Strobe monitor: log every strobe-low cycle and count rule violations.
  always @(negedge i_clk) begin
    automatic int nlow;
    nlow = 0;
    if (!i_reset) begin
      if (!o_ctrlMemMar1NWE)  begin nlow++; ev.push_back('{K_MAR1,  o_bus, cyc}); end
      if (!o_ctrlMemMar0NWE)  begin nlow++; ev.push_back('{K_MAR0,  o_bus, cyc}); end
      if (!o_ctrlMemRamNWE)   begin nlow++; ev.push_back('{K_RAM,   o_bus, cyc}); end
      if (!o_ctrlMemInstrNWE) begin nlow++; ev.push_back('{K_INSTR, o_bus, cyc}); end
      if (nlow > 1) viol++;
      if (nlow > 0 && !o_busOE) viol++;
      if (nlow > 0 && o_rxReady) viol++;
    end
  end

  // Called and returns at a negedge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    i_rxData  = b;
    i_rxValid = 1'b1;
    while (!o_rxReady && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("send_timeout", 32'(n >= 200), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    acc_cyc   = cyc;
    i_rxValid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!o_done && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, o_done, 1);
  endtask

  task automatic exp_push(input int k, input logic [7:0] v);
    exp_q.push_back({k[1:0], v});
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, ev.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), {ev[i].k[1:0], ev[i].v}, exp_q[i]);
    ev.delete();
    exp_q.delete();
  endtask

  initial begin
    int a_cyc, bad, nram, nmar1, idx;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    // Reset state
    check("rst_rxReady", o_rxReady, 1);
    check("rst_haltReq", o_haltReq, 0);
    check("rst_busOE",   o_busOE,   0);
    check("rst_bus",     o_bus,     8'h00);
    check("rst_strobes", {o_ctrlMemMar1NWE, o_ctrlMemMar0NWE, o_ctrlMemRamNWE, o_ctrlMemInstrNWE}, 4'hF);
    check("rst_done",    o_done,    0);
    check("rst_error",   o_error,   0);

    // Single RAM write with exact cycle timing
    send(8'h57); send(8'h12); send(8'h34); send(8'h01); send(8'hAB);
    a_cyc = acc_cyc;
    wait_done("t1_done");
    check("t1_done_cyc", cyc - a_cyc, 10);
    check("t1_haltReq_fall", o_haltReq, 0);
    check("t1_busOE_fall", o_busOE, 0);
    check("t1_mar1_cyc", ev[0].c - a_cyc, 2);
    check("t1_mar0_cyc", ev[1].c - a_cyc, 5);
    check("t1_ram_cyc",  ev[2].c - a_cyc, 8);
    exp_push(K_MAR1, 8'h12); exp_push(K_MAR0, 8'h34); exp_push(K_RAM, 8'hAB);
    check_seq("t1");
    @(negedge i_clk);
    check("t1_idle_ready", o_rxReady, 1);

    // Instruction write, 3 bytes; second byte timing has no MAR1 slot
    send(8'h49); send(8'h00); send(8'h10); send(8'h03);
    send(8'h01); send(8'h02);
    a_cyc = acc_cyc;
    while (!o_rxReady && cyc - a_cyc < 50) @(negedge i_clk);
    check("t2_ready_back_cyc", cyc - a_cyc, 7);
    send(8'h03);
    wait_done("t2_done");
    exp_push(K_MAR1, 8'h00); exp_push(K_MAR0, 8'h10); exp_push(K_INSTR, 8'h01);
    exp_push(K_MAR0, 8'h11); exp_push(K_INSTR, 8'h02);
    exp_push(K_MAR0, 8'h12); exp_push(K_INSTR, 8'h03);
    check("t2_mar0_cyc", ev[3].c - a_cyc, 2);
    check("t2_instr_cyc", ev[4].c - a_cyc, 5);
    check_seq("t2");

    // Address wrap FFFE -> FFFF -> 0000
    send(8'h57); send(8'hFF); send(8'hFE); send(8'h03);
    send(8'hA1); send(8'hA2); send(8'hA3);
    wait_done("t3_done");
    exp_push(K_MAR1, 8'hFF); exp_push(K_MAR0, 8'hFE); exp_push(K_RAM, 8'hA1);
    exp_push(K_MAR0, 8'hFF); exp_push(K_RAM, 8'hA2);
    exp_push(K_MAR1, 8'h00); exp_push(K_MAR0, 8'h00); exp_push(K_RAM, 8'hA3);
    check_seq("t3");

    // LEN=0 -> 256 bytes, random gaps; start 20F0 so MAR1 is rewritten once
    send(8'h57); send(8'h20); send(8'hF0); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      send(i[7:0]);
    end
    wait_done("t4_done");
    bad = 0; nram = 0; nmar1 = 0;
    foreach (ev[j]) begin
      if (ev[j].k == K_RAM) begin
        if (ev[j].v != nram[7:0]) bad++;
        nram++;
      end
      if (ev[j].k == K_MAR1) nmar1++;
    end
    check("t4_ram_strobes", nram, 256);
    check("t4_ram_values_bad", bad, 0);
    check("t4_mar1_writes", nmar1, 2);
    ev.delete();

    // Halt handshake held off 20 cycles
    i_haltAck = 1'b0;
    send(8'h57); send(8'h00); send(8'h40); send(8'h01);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_busOE || o_rxReady || !o_haltReq ||
          !(o_ctrlMemMar1NWE && o_ctrlMemMar0NWE && o_ctrlMemRamNWE && o_ctrlMemInstrNWE))
        bad++;
      @(negedge i_clk);
    end
    check("t5_halt_wait_bad", bad, 0);
    check("t5_no_strobes", ev.size(), 0);
    i_haltAck = 1'b1;
    @(negedge i_clk);
    check("t5_busOE_after_ack", o_busOE, 1);
    check("t5_ready_after_ack", o_rxReady, 1);
    send(8'h5A);
    wait_done("t5_done");
    exp_push(K_MAR1, 8'h00); exp_push(K_MAR0, 8'h40); exp_push(K_RAM, 8'h5A);
    check_seq("t5");

    // Unknown command sets sticky error and is dropped
    check("t6_error_before", o_error, 0);
    send(8'h00);
    check("t6_error_set", o_error, 1);
    check("t6_ready_idle", o_rxReady, 1);

    // Reset during MEM strobe
    send(8'h57); send(8'h00); send(8'h50); send(8'h01); send(8'h77);
    idx = 0;
    while (o_ctrlMemRamNWE && idx < 50) begin
      @(negedge i_clk);
      idx++;
    end
    check("t6_ram_strobe_seen", o_ctrlMemRamNWE, 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("t6_rst_strobes", {o_ctrlMemMar1NWE, o_ctrlMemMar0NWE, o_ctrlMemRamNWE, o_ctrlMemInstrNWE}, 4'hF);
    check("t6_rst_busOE", o_busOE, 0);
    check("t6_rst_haltReq", o_haltReq, 0);
    check("t6_rst_error", o_error, 0);
    i_reset = 1'b0;
    ev.delete();
    @(negedge i_clk);

    // New packet after reset completes normally
    send(8'h49); send(8'h00); send(8'h60); send(8'h01); send(8'h33);
    wait_done("t7_done");
    exp_push(K_MAR1, 8'h00); exp_push(K_MAR0, 8'h60); exp_push(K_INSTR, 8'h33);
    check_seq("t7");

    check("strobe_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
